// File: rtl/add_rc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_rc_pkg
// Description : Shared types and constants for the addRC round-constant pass.
//               Holds the controller state encoding and the datapath geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package add_rc_pkg;

    localparam int NUM_SLICES = 64;   // slices per state pass
    localparam int SLICE_W    = 25;   // bits per slice (5x5 lanes)
    localparam int ROUND_W    = 5;    // width of the round index
    localparam int NUM_ROUNDS = 24;   // legal rounds are 0..NUM_ROUNDS-1

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_XOR   = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/add_rc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : add_rc_controller_if
// Description : Handshake and datapath-control bundle of the addRC controller.
//               master : host/datapath side (drives start, abort, round_idx,
//                        cnt_co_64; observes strobes and status)
//               slave  : controller side
// Ports       : start, abort, round_idx[4:0], cnt_co_64            (to ctrl)
//               cnt_rst_64, cnt_en_64, inreg_en, xor_en, mem_rd_en,
//               mem_wr_en, round_q[4:0], ready, busy, done, err  (from ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface add_rc_controller_if;
    import add_rc_pkg::*;

    logic               start;
    logic               abort;
    logic [ROUND_W-1:0] round_idx;
    logic               cnt_co_64;

    logic               cnt_rst_64;
    logic               cnt_en_64;
    logic               inreg_en;
    logic               xor_en;
    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [ROUND_W-1:0] round_q;
    logic               ready;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, round_idx, cnt_co_64,
        input  cnt_rst_64, cnt_en_64, inreg_en, xor_en, mem_rd_en, mem_wr_en,
        input  round_q, ready, busy, done, err
    );

    modport slave (
        input  start, abort, round_idx, cnt_co_64,
        output cnt_rst_64, cnt_en_64, inreg_en, xor_en, mem_rd_en, mem_wr_en,
        output round_q, ready, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/add_rc_controller.sv
`default_nettype none
// ============================================================================
// Module      : add_rc_controller
// Description : Sequencer for one addRC pass over the state memory. Each slice
//               is walked READ -> LOAD -> XOR -> WRITE; the slice counter lives
//               in the datapath and reports its last slice on cnt_co_64.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               bus        - add_rc_controller_if.slave (handshake + strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module add_rc_controller
    import add_rc_pkg::*;
#(
    parameter int NUM_SLICES = add_rc_pkg::NUM_SLICES,
    parameter int NUM_ROUNDS = add_rc_pkg::NUM_ROUNDS
) (
    input  wire logic            clk,
    input  wire logic            rst,
    add_rc_controller_if.slave   bus
);

    // Round limit held one bit wider than the index so NUM_ROUNDS = 2**ROUND_W fits.
    localparam logic [ROUND_W:0] c_ROUND_LIMIT = NUM_ROUNDS[ROUND_W:0];

    if (NUM_SLICES < 1 || NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << ROUND_W)) begin : g_param_check
        $error("add_rc_controller: NUM_SLICES/NUM_ROUNDS out of range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROUND_W-1:0] r_round;
    logic               r_err;
    logic               w_round_legal;
    logic               w_accept;
    logic               w_reject;

    assign w_round_legal = ({1'b0, bus.round_idx} < c_ROUND_LIMIT);
    assign w_accept      = (r_state == ST_IDLE) && bus.start &&  w_round_legal;
    assign w_reject      = (r_state == ST_IDLE) && bus.start && !w_round_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // err is a single-cycle pulse following a rejected start.
            r_err   <= w_reject;
            if (w_accept) begin
                r_round <= bus.round_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.cnt_rst_64 = 1'b0;
        bus.cnt_en_64  = 1'b0;
        bus.inreg_en   = 1'b0;
        bus.xor_en     = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.ready      = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                bus.ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                bus.cnt_rst_64 = 1'b1;
                w_state_nxt    = ST_READ;
            end
            ST_READ: begin
                bus.mem_rd_en = 1'b1;
                w_state_nxt   = ST_LOAD;
            end
            ST_LOAD: begin
                bus.inreg_en = 1'b1;
                w_state_nxt  = ST_XOR;
            end
            ST_XOR: begin
                bus.xor_en  = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                bus.mem_wr_en = 1'b1;
                // Counter is left parked on the last slice when the pass ends.
                if (bus.cnt_co_64) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    bus.cnt_en_64 = 1'b1;
                    w_state_nxt   = ST_READ;
                end
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort only redirects the next state; this cycle's strobes still go out.
        if (r_state != ST_IDLE) begin
            bus.busy = 1'b1;
            if (bus.abort) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign bus.round_q = r_round;
    assign bus.err     = r_err;

endmodule
`default_nettype wire
